spi_pkt_master: RTL and testbench

Host-side packet initiator for the SPI control link into the transmitter. It turns single-cycle commands into framed SPI packets for the transmitter's packet controller: type byte, length byte, then payload. It drives a byte-level SPI master engine and returns the FIFO free-space reply to the host logic. It is the other end of the transmitter's SPI packet controller: GET_SPACE (type 1), SET_FREQ (type 2) and FIFO_DATA (type 3).

---
 rtl/spi_pkt_master.sv | 146 ++++++++++++++
 tb/tb_spi_pkt_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pkt_master.sv
// Host-side SPI packet initiator: frames GET_SPACE / SET_FREQ / FIFO_DATA packets
// for a byte-level SPI engine and decodes the sync and free-space reply bytes.
module spi_pkt_master #(
  parameter int CS_SETUP_CYC = 2,
  parameter int GAP_CYC      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_type,
  input  logic [7:0]  i_cmd_arg0,
  input  logic [7:0]  i_cmd_arg1,
  output logic        o_tx_cs,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_byte,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_byte,
  input  logic [7:0]  i_smp_data,
  input  logic        i_smp_valid,
  output logic        o_smp_ready,
  output logic [11:0] o_space_free,
  output logic        o_space_valid,
  output logic        o_sync_err,
  output logic        o_busy
);

  // state   | meaning
  // S_IDLE  | waiting for a command, cmd_ready high
  // S_DROP  | one-cycle sink for a no-op command
  // S_SETUP | tx_cs high, counting CS_SETUP_CYC before the first byte
  // S_SEND  | issue tx_start for the current byte (stalls on payload without a sample)
  // S_WAIT  | one byte outstanding, waiting for rx_done
  // S_GAP   | tx_cs low, counting GAP_CYC before returning to idle
  typedef enum logic [2:0] {S_IDLE, S_DROP, S_SETUP, S_SEND, S_WAIT, S_GAP} state_t;

  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  state_t      r_state, w_next;
  logic [1:0]  r_type;
  logic [7:0]  r_arg0, r_arg1;
  logic [8:0]  r_cnt, r_idx;
  logic [7:0]  r_tmr;
  logic [3:0]  r_hi;
  logic [11:0] r_space_free;
  logic        r_space_valid, r_sync_err;

  logic        w_accept, w_tx_start, w_smp_ready, w_payload, w_last;
  logic [7:0]  w_byte;

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_tx_start  = 1'b0;
    w_smp_ready = 1'b0;
    w_payload   = (r_type == 2'd3) && (r_idx >= 9'd2);
    w_last      = (r_cnt == 9'd1);

    unique case (r_idx)
      9'd0:    w_byte = {6'b0, r_type};
      9'd1:    w_byte = (r_type == 2'd3) ? r_arg0 : 8'h02;
      9'd2:    w_byte = (r_type == 2'd2) ? r_arg0 : 8'h00;
      9'd3:    w_byte = (r_type == 2'd2) ? r_arg1 : 8'h00;
      default: w_byte = 8'h00;
    endcase
    if (w_payload) w_byte = i_smp_data;

    unique case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_accept = 1'b1;
          w_next   = (i_cmd_type == 2'd0) ? S_DROP : S_SETUP;
        end
      end
      S_DROP:  w_next = S_IDLE;
      S_SETUP: if (r_tmr == 8'd0) w_next = S_SEND;
      S_SEND: begin
        if (!w_payload || i_smp_valid) begin
          w_tx_start  = 1'b1;
          w_smp_ready = w_payload;
          w_next      = S_WAIT;
        end
      end
      S_WAIT:  if (i_rx_done) w_next = w_last ? S_GAP : S_SEND;
      S_GAP:   if (r_tmr == 8'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_type        <= 2'd0;
      r_arg0        <= 8'h00;
      r_arg1        <= 8'h00;
      r_cnt         <= 9'd0;
      r_idx         <= 9'd0;
      r_tmr         <= 8'd0;
      r_hi          <= 4'h0;
      r_space_free  <= 12'h000;
      r_space_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_space_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      if ((r_state == S_SETUP || r_state == S_GAP) && r_tmr != 8'd0)
        r_tmr <= r_tmr - 8'd1;
      if (w_accept) begin
        r_type <= i_cmd_type;
        r_arg0 <= i_cmd_arg0;
        r_arg1 <= i_cmd_arg1;
        r_cnt  <= (i_cmd_type == 2'd3) ? ({1'b0, i_cmd_arg0} + 9'd2) : 9'd4;
        r_idx  <= 9'd0;
        r_tmr  <= SETUP_LD;
      end
      // reply bytes are only meaningful while a transfer is outstanding
      if (r_state == S_WAIT && i_rx_done) begin
        r_cnt <= r_cnt - 9'd1;
        r_idx <= r_idx + 9'd1;
        if (w_last) r_tmr <= GAP_LD;
        if (r_idx == 9'd0 && i_rx_byte != 8'hA5) r_sync_err <= 1'b1;
        if (r_type == 2'd1 && r_idx == 9'd2) r_hi <= i_rx_byte[3:0];
        if (r_type == 2'd1 && r_idx == 9'd3) begin
          r_space_free  <= {r_hi, i_rx_byte};
          r_space_valid <= 1'b1;
        end
      end
    end
  end

  assign o_cmd_ready   = (r_state == S_IDLE) && !rst;
  assign o_tx_cs       = (r_state == S_SETUP) || (r_state == S_SEND) || (r_state == S_WAIT);
  assign o_tx_start    = w_tx_start;
  assign o_tx_byte     = w_tx_start ? w_byte : 8'h00;
  assign o_smp_ready   = w_smp_ready;
  assign o_space_free  = r_space_free;
  assign o_space_valid = r_space_valid;
  assign o_sync_err    = r_sync_err;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_pkt_master.sv
// Bench for spi_pkt_master: behavioural SPI engine responder, negedge monitor,
// expected-byte scoreboard queue filled at command issue and drained after each packet.
module tb_spi_pkt_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [1:0]  i_cmd_type = 2'd0;
  logic [7:0]  i_cmd_arg0 = 8'h00, i_cmd_arg1 = 8'h00;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [7:0]  i_smp_data = 8'h00;
  logic        i_smp_valid = 1'b0;
  logic        o_cmd_ready, o_tx_cs, o_tx_start, o_smp_ready, o_space_valid, o_sync_err, o_busy;
  logic [7:0]  o_tx_byte;
  logic [11:0] o_space_free;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int n_txs = 0, n_smp = 0, n_sv = 0, n_se = 0;
  int sv_cyc = 0, se_cyc = 0, cs_fall = 0;
  logic prev_cs = 1'b0;
  logic [7:0] exp_q[$], cap_q[$], reply_q[$];
  int cap_c[$], rx_c[$];
  logic eng_pend = 1'b0;
  int eng_dly = 0;

  spi_pkt_master #(.CS_SETUP_CYC(2), .GAP_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_type(i_cmd_type),
    .i_cmd_arg0(i_cmd_arg0), .i_cmd_arg1(i_cmd_arg1),
    .o_tx_cs(o_tx_cs), .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte),
    .i_rx_done(rx_done), .i_rx_byte(rx_byte),
    .i_smp_data(i_smp_data), .i_smp_valid(i_smp_valid), .o_smp_ready(o_smp_ready),
    .o_space_free(o_space_free), .o_space_valid(o_space_valid), .o_sync_err(o_sync_err),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI engine: rx_done three cycles after tx_start, reply bytes from reply_q (default A5)
  always @(posedge clk) begin
    rx_done <= 1'b0;
    if (rst) eng_pend <= 1'b0;
    else begin
      if (eng_pend) begin
        if (eng_dly == 0) begin
          rx_done  <= 1'b1;
          eng_pend <= 1'b0;
          if (reply_q.size() > 0) begin rx_byte <= reply_q[0]; reply_q.delete(0); end
          else rx_byte <= 8'hA5;
        end else eng_dly <= eng_dly - 1;
      end
      if (o_tx_start) begin eng_pend <= 1'b1; eng_dly <= 1; end
    end
  end

  always @(negedge clk) begin
    if (o_tx_start) begin cap_q.push_back(o_tx_byte); cap_c.push_back(cyc); n_txs <= n_txs + 1; end
    if (o_smp_ready) n_smp <= n_smp + 1;
    if (o_space_valid) begin n_sv <= n_sv + 1; sv_cyc <= cyc; end
    if (o_sync_err) begin n_se <= n_se + 1; se_cyc <= cyc; end
    if (rx_done) rx_c.push_back(cyc);
    if (prev_cs && !o_tx_cs) cs_fall <= cyc;
    prev_cs <= o_tx_cs;
  end

  task automatic issue(input logic [1:0] t, input logic [7:0] a0, input logic [7:0] a1, output int k);
    k = -1;
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_type = t; i_cmd_arg0 = a0; i_cmd_arg1 = a1;
    for (int n = 0; n < 50; n++) begin
      if (o_cmd_ready) break;
      @(negedge clk);
    end
    if (o_cmd_ready) begin @(posedge clk); #1; k = cyc; end
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int ic);
    ic = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!o_busy) begin ic = cyc; break; end
    end
    @(negedge clk);
  endtask

  task automatic clear_caps();
    cap_q.delete(); cap_c.delete(); rx_c.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++; if (o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready actual=%b required=0", o_cmd_ready); end
    n_vec++;
    if ({o_tx_cs, o_tx_start, o_smp_ready, o_space_valid, o_sync_err, o_busy} !== 6'b0 ||
        o_tx_byte !== 8'h00 || o_space_free !== 12'h000) begin
      n_err++; $display("FAIL reset_outputs actual=cs%b st%b sr%b sv%b se%b bz%b tb%h sf%h required=all0",
        o_tx_cs, o_tx_start, o_smp_ready, o_space_valid, o_sync_err, o_busy, o_tx_byte, o_space_free);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (o_cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready actual=%b required=1", o_cmd_ready); end
  endtask

  task automatic test_set_freq();
    int k, ic, t0, s0;
    logic [7:0] e, a;
    clear_caps();
    exp_q.push_back(8'h02); exp_q.push_back(8'h02); exp_q.push_back(8'h05); exp_q.push_back(8'h3C);
    reply_q.push_back(8'hA5);
    t0 = n_txs; s0 = n_se;
    issue(2'd2, 8'h05, 8'h3C, k);
    @(negedge clk);
    n_vec++; if (o_tx_cs !== 1'b1 || o_cmd_ready !== 1'b0) begin n_err++; $display("FAIL setfreq_cs_after_accept actual=cs%b rdy%b required=cs1 rdy0", o_tx_cs, o_cmd_ready); end
    wait_idle(ic);
    n_vec++; if (ic < 0 || k < 0) begin n_err++; $display("FAIL setfreq_timeout actual=%0d required=idle", ic); end
    n_vec++; if (cap_c.size() == 0 || cap_c[0] != k + 2) begin n_err++; $display("FAIL setfreq_first_start actual=%0d required=%0d", (cap_c.size() > 0) ? cap_c[0] : -1, k + 2); end
    n_vec++; if (n_txs - t0 != 4) begin n_err++; $display("FAIL setfreq_starts actual=%0d required=4", n_txs - t0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (cap_q.size() == 0) begin n_err++; $display("FAIL setfreq_byte actual=none required=%h", e); end
      else begin a = cap_q.pop_front(); if (a !== e) begin n_err++; $display("FAIL setfreq_byte actual=%h required=%h", a, e); end end
    end
    if (rx_c.size() > 0) begin
      n_vec++; if (cs_fall != rx_c[$] + 1) begin n_err++; $display("FAIL setfreq_cs_fall actual=%0d required=%0d", cs_fall, rx_c[$] + 1); end
      n_vec++; if (ic != rx_c[$] + 5) begin n_err++; $display("FAIL setfreq_gap actual=%0d required=%0d", ic, rx_c[$] + 5); end
    end else begin
      n_vec++; n_err++; $display("FAIL setfreq_rx actual=0 required=4");
    end
    n_vec++; if (n_se != s0) begin n_err++; $display("FAIL setfreq_sync_err actual=%0d required=0", n_se - s0); end
  endtask

  task automatic test_get_space();
    int k, ic, v0;
    logic [7:0] e, a;
    clear_caps();
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    reply_q.push_back(8'hA5); reply_q.push_back(8'h00); reply_q.push_back(8'hF7); reply_q.push_back(8'h2B);
    v0 = n_sv;
    issue(2'd1, 8'h00, 8'h00, k);
    wait_idle(ic);
    n_vec++; if (ic < 0 || k < 0) begin n_err++; $display("FAIL getspace_timeout actual=%0d required=idle", ic); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (cap_q.size() == 0) begin n_err++; $display("FAIL getspace_byte actual=none required=%h", e); end
      else begin a = cap_q.pop_front(); if (a !== e) begin n_err++; $display("FAIL getspace_byte actual=%h required=%h", a, e); end end
    end
    n_vec++; if (o_space_free !== 12'h72B) begin n_err++; $display("FAIL getspace_value actual=%h required=72b", o_space_free); end
    n_vec++; if (n_sv - v0 != 1) begin n_err++; $display("FAIL getspace_valid_count actual=%0d required=1", n_sv - v0); end
    n_vec++; if (rx_c.size() != 4 || sv_cyc != rx_c[$] + 1) begin n_err++; $display("FAIL getspace_valid_time actual=%0d required=rx4+1 (rx=%0d)", sv_cyc, rx_c.size()); end
  endtask

  task automatic test_fifo_stall();
    int k, ic, m0, j;
    logic bad, sr;
    logic [7:0] p[3];
    logic [7:0] e, a;
    p[0] = 8'h11; p[1] = 8'h22; p[2] = 8'h33;
    clear_caps();
    exp_q.push_back(8'h03); exp_q.push_back(8'h03);
    for (int i = 0; i < 3; i++) exp_q.push_back(p[i]);
    m0 = n_smp; i_smp_valid = 1'b0;
    issue(2'd3, 8'h03, 8'h00, k);
    for (int n = 0; n < 60; n++) begin
      if (rx_c.size() >= 2) break;
      @(negedge clk);
    end
    bad = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o_tx_cs !== 1'b1 || o_tx_start !== 1'b0 || o_smp_ready !== 1'b0) bad = 1'b1;
    end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL fifo_stall_hold actual=broke required=cs_high_no_start"); end
    @(posedge clk); #1;
    j = 0; i_smp_valid = 1'b1; i_smp_data = p[0];
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); sr = o_smp_ready;
      @(posedge clk); #1;
      if (sr) begin
        j++;
        if (j == 3) begin i_smp_valid = 1'b0; break; end
        i_smp_data = p[j];
      end
    end
    i_smp_valid = 1'b0;
    wait_idle(ic);
    n_vec++; if (ic < 0 || k < 0) begin n_err++; $display("FAIL fifo_timeout actual=%0d required=idle", ic); end
    n_vec++; if (n_smp - m0 != 3) begin n_err++; $display("FAIL fifo_smp_ready actual=%0d required=3", n_smp - m0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (cap_q.size() == 0) begin n_err++; $display("FAIL fifo_byte actual=none required=%h", e); end
      else begin a = cap_q.pop_front(); if (a !== e) begin n_err++; $display("FAIL fifo_byte actual=%h required=%h", a, e); end end
    end
  endtask

  task automatic test_edge_cmds();
    int k, ic, t0, m0;
    logic [7:0] e, a;
    clear_caps();
    exp_q.push_back(8'h03); exp_q.push_back(8'h00);
    t0 = n_txs; m0 = n_smp;
    issue(2'd3, 8'h00, 8'h00, k);
    wait_idle(ic);
    n_vec++; if (n_txs - t0 != 2 || n_smp != m0) begin n_err++; $display("FAIL n0_counts actual=st%0d sr%0d required=st2 sr0", n_txs - t0, n_smp - m0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_vec++;
      if (cap_q.size() == 0) begin n_err++; $display("FAIL n0_byte actual=none required=%h", e); end
      else begin a = cap_q.pop_front(); if (a !== e) begin n_err++; $display("FAIL n0_byte actual=%h required=%h", a, e); end end
    end
    t0 = n_txs;
    issue(2'd0, 8'h77, 8'h88, k);
    @(negedge clk);
    n_vec++; if (o_cmd_ready !== 1'b0 || o_tx_cs !== 1'b0) begin n_err++; $display("FAIL nop_after_accept actual=rdy%b cs%b required=rdy0 cs0", o_cmd_ready, o_tx_cs); end
    @(negedge clk);
    n_vec++; if (o_cmd_ready !== 1'b1 || o_tx_cs !== 1'b0 || o_busy !== 1'b0) begin n_err++; $display("FAIL nop_back_idle actual=rdy%b cs%b bz%b required=rdy1 cs0 bz0", o_cmd_ready, o_tx_cs, o_busy); end
    n_vec++; if (n_txs != t0 || k < 0) begin n_err++; $display("FAIL nop_starts actual=%0d required=0", n_txs - t0); end
  endtask

  task automatic test_bad_sync();
    int k, ic, t0, s0;
    clear_caps();
    reply_q.push_back(8'h00);
    t0 = n_txs; s0 = n_se;
    issue(2'd2, 8'h01, 8'h02, k);
    wait_idle(ic);
    n_vec++; if (ic < 0 || n_txs - t0 != 4) begin n_err++; $display("FAIL badsync_complete actual=%0d required=4", n_txs - t0); end
    n_vec++; if (n_se - s0 != 1) begin n_err++; $display("FAIL badsync_count actual=%0d required=1", n_se - s0); end
    n_vec++; if (rx_c.size() == 0 || se_cyc != rx_c[0] + 1) begin n_err++; $display("FAIL badsync_time actual=%0d required=rx0+1", se_cyc); end
  endtask

  task automatic test_reset_mid();
    int k, t0, v0;
    clear_caps();
    t0 = n_txs; v0 = n_sv;
    i_smp_valid = 1'b1; i_smp_data = 8'h5A;
    issue(2'd3, 8'h05, 8'h00, k);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n_txs - t0 >= 3) break;
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (o_tx_cs !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b0 || o_tx_start !== 1'b0 ||
        o_space_free !== 12'h000) begin
      n_err++; $display("FAIL rstmid_outputs actual=cs%b bz%b rdy%b st%b sf%h required=0", o_tx_cs, o_busy, o_cmd_ready, o_tx_start, o_space_free);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; i_smp_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (o_cmd_ready !== 1'b1 || o_tx_cs !== 1'b0) begin n_err++; $display("FAIL rstmid_release actual=rdy%b cs%b required=rdy1 cs0", o_cmd_ready, o_tx_cs); end
    n_vec++; if (n_sv != v0) begin n_err++; $display("FAIL rstmid_space_valid actual=%0d required=0", n_sv - v0); end
    reply_q.delete();
    clear_caps();
  endtask

  initial begin
    test_reset();
    test_set_freq();
    test_get_space();
    test_fifo_stall();
    test_edge_cmds();
    test_bad_sync();
    test_reset_mid();
    test_set_freq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
